// File: rtl/posit_result_arbiter.sv
// Round-robin merge of posit unit results onto one registered channel; 1-cycle latency.
// Grants only when the output register is empty or draining; a stalled output withholds all unit readies.
package posit_pkg;
   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;
endpackage

module posit_result_arbiter #(
   parameter  int WIDTH     = 32,
   parameter  int NUM_UNITS = 3,
   localparam int TAG_W     = $clog2(NUM_UNITS)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [NUM_UNITS-1:0][WIDTH-1:0]        unit_result_i,
   input  posit_pkg::status_t [NUM_UNITS-1:0]     unit_status_i,
   input  logic [NUM_UNITS-1:0]                   unit_valid_i,
   output logic [NUM_UNITS-1:0]                   unit_ready_o,
   input  logic                                   flush_i,
   output logic [WIDTH-1:0]                       result_o,
   output posit_pkg::status_t                     status_o,
   output logic [TAG_W-1:0]                       tag_o,
   output logic                                   out_valid_o,
   input  logic                                   out_ready_i,
   output logic                                   busy_o
);

   logic [WIDTH-1:0]   result_q;
   posit_pkg::status_t status_q;
   logic [TAG_W-1:0]   tag_q;
   logic               valid_q;
   logic [TAG_W-1:0]   rr_q;

   logic               can_accept;
   logic               gnt_vld;
   logic [TAG_W-1:0]   gnt_idx;
   logic [TAG_W-1:0]   rr_nxt;
   logic [TAG_W:0]     probe;
   logic               xfer;

   assign can_accept = !valid_q || out_ready_i;
   assign xfer       = gnt_vld && can_accept && !flush_i;

   // Scan from the farthest offset down so the closest valid unit to rr_q wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      probe   = '0;
      for (int k = NUM_UNITS - 1; k >= 0; k--) begin
         probe = {1'b0, rr_q} + (TAG_W+1)'(k);
         if (probe >= (TAG_W+1)'(NUM_UNITS)) begin
            probe = probe - (TAG_W+1)'(NUM_UNITS);
         end
         if (unit_valid_i[probe[TAG_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = probe[TAG_W-1:0];
         end
      end
   end

   assign rr_nxt = (gnt_idx == TAG_W'(NUM_UNITS - 1)) ? '0 : gnt_idx + TAG_W'(1);

   always_comb begin
      unit_ready_o = '0;
      if (xfer) begin
         unit_ready_o[gnt_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         result_q <= '0;
         status_q <= '0;
         tag_q    <= '0;
         valid_q  <= 1'b0;
         rr_q     <= '0;
      end else if (flush_i) begin
         valid_q  <= 1'b0;
      end else if (xfer) begin
         result_q <= unit_result_i[gnt_idx];
         status_q <= unit_status_i[gnt_idx];
         tag_q    <= gnt_idx;
         valid_q  <= 1'b1;
         rr_q     <= rr_nxt;
      end else if (valid_q && out_ready_i) begin
         valid_q  <= 1'b0;
      end
   end

   assign result_o    = result_q;
   assign status_o    = status_q;
   assign tag_o       = tag_q;
   assign out_valid_o = valid_q;
   assign busy_o      = valid_q || (|unit_valid_i);

endmodule

// File: tb/tb_posit_result_arbiter.sv
// Directed and random checks of posit_result_arbiter against a cycle-level reference model.
module tb_posit_result_arbiter;
   import posit_pkg::*;

   localparam int N  = 3;
   localparam int W  = 32;
   localparam int TW = $clog2(N);

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [N-1:0][W-1:0] u_res = '0;
   status_t [N-1:0]     u_st = '0;
   logic [N-1:0]        u_vld = '0;
   logic [N-1:0]        u_rdy;
   logic                flush = 1'b0;
   logic                out_rdy = 1'b1;
   logic [W-1:0]        res;
   status_t             st;
   logic [TW-1:0]       tag;
   logic                out_vld;
   logic                busy;

   int total = 0;
   int bad   = 0;

   // reference model state
   int       m_rr;
   bit       m_vld;
   logic [W-1:0] m_res;
   status_t  m_st;
   int       m_tag;
   int       m_g;
   bit       m_xfer;
   logic [W-1:0] saved;

   always #5 clk = ~clk;

   posit_result_arbiter #(.WIDTH(W), .NUM_UNITS(N)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .unit_result_i(u_res), .unit_status_i(u_st),
      .unit_valid_i(u_vld), .unit_ready_o(u_rdy),
      .flush_i(flush),
      .result_o(res), .status_o(st), .tag_o(tag),
      .out_valid_o(out_vld), .out_ready_i(out_rdy),
      .busy_o(busy)
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_rr = 0; m_vld = 0; m_res = '0; m_st = '0; m_tag = 0; m_g = -1; m_xfer = 0;
   endtask

   // Combinational checks for the current inputs, before the edge.
   task automatic pre();
      logic [N-1:0] er;
      #1;
      m_g = -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_rr + k) % N;
         if (m_g < 0 && u_vld[idx[TW-1:0]]) m_g = idx;
      end
      er = '0;
      if (m_g >= 0 && (!m_vld || out_rdy) && !flush) er = N'(1) << m_g;
      m_xfer = (er != '0);
      chk("ready", 64'(u_rdy), 64'(er));
      chk("busy", 64'(busy), 64'(m_vld || (u_vld != '0)));
   endtask

   // Clock edge, model update, registered-output checks.
   task automatic post();
      @(posedge clk);
      if (flush) m_vld = 0;
      else if (m_xfer) begin
         m_vld = 1;
         m_res = u_res[m_g[TW-1:0]];
         m_st  = u_st[m_g[TW-1:0]];
         m_tag = m_g;
         m_rr  = (m_g + 1) % N;
      end else if (m_vld && out_rdy) m_vld = 0;
      #1;
      chk("out_valid", 64'(out_vld), 64'(m_vld));
      chk("result", 64'(res), 64'(m_res));
      chk("status", 64'(st), 64'(m_st));
      chk("tag", 64'(tag), 64'(m_tag));
   endtask

   task automatic cycle();
      pre();
      post();
   endtask

   initial begin
      model_reset();
      #1;
      chk("rst_valid", 64'(out_vld), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_tag", 64'(tag), 64'(0));
      chk("rst_result", 64'(res), 64'(0));
      chk("rst_status", 64'(st), 64'(0));
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // single result from unit 1
      u_vld = 3'b010; u_res[1] = 32'h4000_0000; u_st[1] = '0;
      pre();
      chk("t1_ready", 64'(u_rdy), 64'(3'b010));
      post();
      chk("t1_result", 64'(res), 64'h4000_0000);
      chk("t1_tag", 64'(tag), 64'(1));
      chk("t1_valid", 64'(out_vld), 64'(1));
      u_vld = '0;
      cycle();

      // reset mid-operation returns pointer to 0 and drops buffered data
      u_vld = 3'b001; u_res[0] = 32'h1234_5678;
      cycle();
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(out_vld), 64'(0));
      chk("midrst_tag", 64'(tag), 64'(0));
      model_reset();
      rst_n = 1'b1;

      // fairness with all units valid
      u_vld = '1;
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < N; j++) u_res[j] = $urandom;
         cycle();
         chk("rr_tag", 64'(tag), 64'(i % N));
         chk("rr_valid", 64'(out_vld), 64'(1));
      end

      // backpressure: no readies, stable outputs
      out_rdy = 1'b0; u_vld = 3'b101; saved = res;
      for (int i = 0; i < 4; i++) begin
         pre();
         chk("bp_ready", 64'(u_rdy), 64'(0));
         post();
         chk("bp_result", 64'(res), 64'(saved));
         chk("bp_tag", 64'(tag), 64'(2));
      end
      out_rdy = 1'b1;
      pre();
      chk("bp_release_ready", 64'(u_rdy), 64'(3'b001));
      post();
      chk("bp_release_tag", 64'(tag), 64'(0));

      // drain and load in the same cycle, with NV from unit 2
      u_vld = 3'b100; u_res[2] = 32'h8000_0000; u_st[2] = '0; u_st[2].nv = 1'b1;
      pre();
      chk("dl_ready", 64'(u_rdy), 64'(3'b100));
      post();
      chk("dl_valid", 64'(out_vld), 64'(1));
      chk("dl_result", 64'(res), 64'h8000_0000);
      chk("dl_nv", 64'(st.nv), 64'(1));
      chk("dl_tag", 64'(tag), 64'(2));

      // pointer wrapped to 0
      u_vld = 3'b011;
      pre();
      chk("wrap_ready", 64'(u_rdy), 64'(3'b001));
      post();
      chk("wrap_tag", 64'(tag), 64'(0));

      // flush with data buffered
      flush = 1'b1; u_vld = 3'b001;
      pre();
      chk("flush_ready", 64'(u_rdy), 64'(0));
      post();
      chk("flush_valid", 64'(out_vld), 64'(0));
      flush = 1'b0; u_vld = 3'b111;
      pre();
      chk("flush_resume", 64'(u_rdy), 64'(3'b010));
      post();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         u_vld   = N'($urandom);
         out_rdy = ($urandom_range(0, 3) != 0);
         flush   = ($urandom_range(0, 19) == 0);
         for (int j = 0; j < N; j++) begin
            u_res[j] = $urandom;
            u_st[j]  = status_t'($urandom_range(0, 31));
         end
         if ($urandom_range(0, 149) == 0) begin
            rst_n = 1'b0;
            #1;
            chk("rnd_rst_valid", 64'(out_vld), 64'(0));
            model_reset();
            rst_n = 1'b1;
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
